// File: rtl/gaussian_window_sched_if.sv
// Handshake bundle between the Gaussian frame sequencer and its FIFOs/datapath.
// The master side drives start, in_empty and out_rd; the scheduler sits on the slave side.
interface gaussian_window_sched_if #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540
);
    localparam int unsigned XW = $clog2(IMG_WIDTH + 5);
    localparam int unsigned YW = $clog2(IMG_HEIGHT + 5);

    logic          start;
    logic          in_empty;
    logic          in_rd_en;
    logic          win_shift;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          out_rd;
    logic          out_wr_en;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        output start, in_empty, out_rd,
        input  in_rd_en, win_shift, x, y, out_wr_en, out_last, busy, done
    );

    modport slave (
        input  start, in_empty, out_rd,
        output in_rd_en, win_shift, x, y, out_wr_en, out_last, busy, done
    );
endinterface

// File: rtl/gaussian_window_sched.sv
// Frame sequencer for the 5x5 Gaussian datapath: sweeps the padded raster, pops input pixels,
// and lines up the output FIFO write strobe with the fixed-latency, non-stallable datapath.
module gaussian_window_sched #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned LATENCY    = 19,
    parameter int unsigned OUT_DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    gaussian_window_sched_if.slave   bus
);
    localparam int unsigned XW = $clog2(IMG_WIDTH + 5);
    localparam int unsigned YW = $clog2(IMG_HEIGHT + 5);
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned DW = $clog2(LATENCY + 1);

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH + 3);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT + 3);
    localparam logic [XW-1:0] X_LAST_EMIT = XW'(IMG_WIDTH + 1);
    localparam logic [YW-1:0] Y_LAST_EMIT = YW'(IMG_HEIGHT + 1);
    localparam logic [CW-1:0] CREDIT_MAX  = CW'(OUT_DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [CW-1:0]       r_credits;
    logic [DW-1:0]       r_drain_cnt;
    logic [LATENCY-1:0]  r_vld;
    logic [LATENCY-1:0]  r_lst;

    logic w_need_rd;
    logic w_emit;
    logic w_step;
    logic w_x_wrap;
    logic w_frame_end;
    logic w_last;
    logic w_take;
    logic w_give;
    logic w_drain_end;

    // Position classification: real pixel to pop, and whether the window centre is inside the image
    assign w_need_rd   = (r_x < XW'(IMG_WIDTH)) && (r_y < YW'(IMG_HEIGHT));
    assign w_emit      = (r_x >= XW'(2)) && (r_x < XW'(IMG_WIDTH + 2)) &&
                         (r_y >= YW'(2)) && (r_y < YW'(IMG_HEIGHT + 2));
    assign w_step      = (r_state == S_RUN) &&
                         (!w_need_rd || !bus.in_empty) &&
                         (!w_emit || (r_credits != '0));
    assign w_x_wrap    = (r_x == X_LAST);
    assign w_frame_end = w_x_wrap && (r_y == Y_LAST);
    assign w_last      = w_step && (r_x == X_LAST_EMIT) && (r_y == Y_LAST_EMIT);
    assign w_take      = w_step && w_emit;
    assign w_give      = bus.out_rd && (r_credits != CREDIT_MAX);
    assign w_drain_end = (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)             w_next_state = S_RUN;
            S_RUN:   if (w_step && w_frame_end) w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_end)           w_next_state = S_DONE;
            S_DONE:                             w_next_state = S_IDLE;
            default:                            w_next_state = S_IDLE;
        endcase
    end

    // Raster position; the final step rewinds to (0,0) for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_step) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_frame_end ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Counts the datapath flush after the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
        end
    end

    // Output FIFO credits; a return that coincides with an issue cancels it out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CREDIT_MAX;
        end else if (w_take && !bus.out_rd) begin
            r_credits <= r_credits - CW'(1);
        end else if (!w_take && w_give) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    // Valid/last pipe mirrors the datapath latency and never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld[0] <= w_take;
            r_lst[0] <= w_last;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    assign bus.in_rd_en  = w_step && w_need_rd;
    assign bus.win_shift = w_step;
    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.out_wr_en = r_vld[LATENCY-1];
    assign bus.out_last  = r_lst[LATENCY-1];
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_gaussian_window_sched.sv
// Bench for gaussian_window_sched on a 4x3 image, latency 3, output depth 4.
// Step positions are checked against a raster index; emitted results go through a due-cycle scoreboard.
module tb_gaussian_window_sched;
    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
    localparam int unsigned L = 3;
    localparam int unsigned D = 4;
    localparam int NCOL  = W + 4;
    localparam int NSTEP = (W + 4) * (H + 4);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gaussian_window_sched_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus();

    gaussian_window_sched #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .LATENCY   (L),
        .OUT_DEPTH (D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int due;
        bit lst;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int step_idx = 0;
    int n_step = 0, n_rd = 0, n_wr = 0, n_last = 0, n_done = 0, done_cyc = 0;
    int b_step, b_rd, b_wr, b_last, b_done;
    int ex, ey, c0;
    bit nr, em;
    bit echo = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: raster order, pop qualification, and scoreboard of emitted results
    always @(negedge clk) begin
        if (rst) begin
            step_idx = 0;
            sb.delete();
        end else begin
            if (bus.win_shift) begin
                ex = step_idx % NCOL;
                ey = step_idx / NCOL;
                nr = (ex < int'(W)) && (ey < int'(H));
                em = (ex >= 2) && (ex < int'(W) + 2) && (ey >= 2) && (ey < int'(H) + 2);
                check_eq("step_x", int'(bus.x), ex);
                check_eq("step_y", int'(bus.y), ey);
                check_eq("rd_on_step", int'(bus.in_rd_en), int'(nr));
                if (em) sb.push_back('{due: cyc + int'(L), lst: (ex == int'(W) + 1) && (ey == int'(H) + 1)});
                n_step++;
                if (bus.in_rd_en) n_rd++;
                step_idx = (step_idx + 1) % NSTEP;
            end else begin
                check_eq("rd_without_step", int'(bus.in_rd_en), 0);
            end
            if (bus.out_wr_en) begin
                n_wr++;
                if (bus.out_last) n_last++;
                check_eq("wr_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("wr_cycle", cyc, e.due);
                    check_eq("wr_last", int'(bus.out_last), int'(e.lst));
                end
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Downstream that pops every written entry in the same cycle
    initial forever begin
        @(posedge clk);
        #2;
        if (echo) bus.out_rd = bus.out_wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic snap();
        b_step = n_step; b_rd = n_rd; b_wr = n_wr; b_last = n_last; b_done = n_done;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (n_done == b_done && k < bound) begin
            tick();
            k++;
        end
        check_eq({tag, "_done_pulses"}, n_done - b_done, 1);
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_steps"}, n_step - b_step, NSTEP);
        check_eq({tag, "_rd"},    n_rd - b_rd, int'(W * H));
        check_eq({tag, "_wr"},    n_wr - b_wr, int'(W * H));
        check_eq({tag, "_last"},  n_last - b_last, 1);
        check_eq({tag, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_x"},         int'(bus.x), 0);
        check_eq({tag, "_y"},         int'(bus.y), 0);
        check_eq({tag, "_in_rd_en"},  int'(bus.in_rd_en), 0);
        check_eq({tag, "_win_shift"}, int'(bus.win_shift), 0);
        check_eq({tag, "_out_wr_en"}, int'(bus.out_wr_en), 0);
        check_eq({tag, "_out_last"},  int'(bus.out_last), 0);
        check_eq({tag, "_busy"},      int'(bus.busy), 0);
        check_eq({tag, "_done"},      int'(bus.done), 0);
    endtask

    task automatic check_pos(input string tag, input int px, input int py, input int shift);
        check_eq({tag, "_x"}, int'(bus.x), px);
        check_eq({tag, "_y"}, int'(bus.y), py);
        check_eq({tag, "_win_shift"}, int'(bus.win_shift), shift);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_empty = 1'b0;
        bus.out_rd = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;

        // Free-running frame
        echo = 1'b1;
        snap();
        c0 = cyc;
        pulse_start();
        wait_done("t1", 120);
        check_eq("t1_done_cycle", done_cyc, c0 + 60);
        check_frame("t1");

        // Upstream empty while sitting at (1,0)
        snap();
        c0 = cyc;
        pulse_start();
        tick();
        bus.in_empty = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_pos("t2_hold", 1, 0, 0);
            check_eq("t2_hold_rd", int'(bus.in_rd_en), 0);
            @(posedge clk); #1;
        end
        bus.in_empty = 1'b0;
        @(negedge clk);
        check_pos("t2_resume", 1, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_pos("t2_after", 2, 0, 1);
        @(posedge clk); #1;
        wait_done("t2", 120);
        check_eq("t2_done_cycle", done_cyc, c0 + 63);
        check_frame("t2");

        // No credit returns: stalls at the fifth emit position
        echo = 1'b0;
        bus.out_rd = 1'b0;
        snap();
        pulse_start();
        repeat (40) tick();
        @(negedge clk);
        check_pos("t3_stall", 2, 3, 0);
        check_eq("t3_busy", int'(bus.busy), 1);
        check_eq("t3_steps", n_step - b_step, 26);
        check_eq("t3_wr", n_wr - b_wr, 4);
        @(posedge clk); #1;
        bus.out_rd = 1'b1;
        tick();
        bus.out_rd = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check_pos("t3_one_more", 3, 3, 0);
        check_eq("t3_steps_after", n_step - b_step, 27);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t3_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Reset during the 20th step of a frame
        echo = 1'b1;
        snap();
        pulse_start();
        repeat (19) tick();
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t5_reset");
        check_eq("t5_steps", n_step - b_step, 19);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // start pulses during RUN and DRAIN are ignored
        snap();
        c0 = cyc;
        pulse_start();
        check_pos("t6_first", 0, 0, 1);
        repeat (9) tick();
        pulse_start();
        repeat (46) tick();
        @(negedge clk);
        check_eq("t6_busy_drain", int'(bus.busy), 1);
        @(posedge clk); #1;
        pulse_start();
        wait_done("t6", 20);
        check_eq("t6_done_cycle", done_cyc, c0 + 60);
        check_frame("t6");
        repeat (10) tick();
        @(negedge clk);
        check_eq("t6_idle_busy", int'(bus.busy), 0);
        check_eq("t6_no_restart", n_step - b_step, NSTEP);
        @(posedge clk); #1;

        // Credit return coinciding with an emitting step at credits=2
        echo = 1'b0;
        bus.out_rd = 1'b0;
        snap();
        pulse_start();
        repeat (20) tick();
        bus.out_rd = 1'b1;
        @(negedge clk);
        check_pos("t4_coincide", 4, 2, 1);
        @(posedge clk); #1;
        bus.out_rd = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check_pos("t4_stall", 3, 3, 0);
        check_eq("t4_steps", n_step - b_step, 27);
        @(posedge clk); #1;
        bus.out_rd = 1'b1;
        tick();
        bus.out_rd = 1'b0;
        echo = 1'b1;
        wait_done("t4", 400);
        check_frame("t4");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
